wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have the following parameter: DEPTH, 2, ALU-result queue entries (fixed at 2 for this revision).
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_dest  in  4  ALU destination register.
- alu_data  in  24  ALU result.
- alu_ready  out  1  queue can accept an ALU result this cycle.
- ld_valid  in  1  load data returning from memory; no back-pressure.
- ld_dest  in  4  load destination register.
- ld_data  in  24  load data.
- reg_write_en  out  1  register-file write strobe.
- reg_write_dest  out  4  register-file write address.
- reg_write_data  out  24  register-file write data.
- busy  out  16  bit r = 1 while a queued ALU result targets register r.
- q_count  out  2  current queue occupancy (0..2).

Function
REQ-004 The block SHALL transfer an ALU result only on a clock edge where alu_valid=1 and alu_ready=1.
REQ-005 While alu_valid=1 and alu_ready=0, the producer holds its values, and the block SHALL NOT capture them.
REQ-006 alu_ready SHALL be 1 exactly when rst=0 and q_count<2.
REQ-007 alu_ready SHALL be derived from the registered occupancy only; a same-cycle dequeue SHALL NOT free a slot for a same-cycle enqueue when the queue is full.
REQ-008 The queue SHALL be in-order; accepted ALU results SHALL leave in acceptance order.
REQ-009 The write-port outputs (reg_write_en, reg_write_dest, reg_write_data) SHALL be registered; each edge SHALL load exactly one of:
- (a) the load, if ld_valid=1;
- (b) otherwise the queue head, if q_count>0, which is then dequeued;
- (c) otherwise idle: reg_write_en=0, with dest and data holding their last values.
REQ-010 Loads SHALL always win arbitration; while ld_valid=1, the queue head SHALL NOT be dequeued.
REQ-011 Load latency SHALL be one edge: a load sampled at edge E drives reg_write_en=1 in the cycle after E.
REQ-012 ALU latency SHALL be a minimum of two edges: a result accepted at edge E is dequeued no earlier than edge E+1.
REQ-013 An ALU result and a load MAY be accepted on the same edge; the load is written first.
REQ-014 When enqueue and dequeue occur on the same edge, q_count SHALL be unchanged.
REQ-015 Queue read and write pointers SHALL wrap modulo 2.
REQ-016 An entry with dest=0 (the $zero register) SHALL be consumed normally, but its output cycle SHALL have reg_write_en=0; this applies to both loads and ALU results.
REQ-017 busy SHALL be the combinational OR of one-hot(dest) over valid queue entries, with bit 0 forced to 0.
REQ-018 Duplicate destinations in the queue SHALL be permitted; the bit stays set until the last matching entry is dequeued.
REQ-019 Ordering between loads and ALU results to the same register is resolved upstream; the block SHALL NOT reorder or merge entries.
REQ-020 Data SHALL pass through unmodified, with full 24-bit width and no sign or width conversion.

Reset
REQ-021 Reset SHALL be sampled on the rising clock edge only.
REQ-022 At reset, the block SHALL set q_count=0, reg_write_en=0, reg_write_dest=0, reg_write_data=0, and busy=0.
REQ-023 A reset asserted mid-operation SHALL discard all queued entries and any load sampled on that edge; no write strobe SHALL follow that edge.
REQ-024 alu_ready SHALL be 0 during any cycle with rst=1, and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-025 Single ALU result: alu_valid at edge 1 with dest=3, data=0x00ABCD -> cycle after edge 2 shows reg_write_en=1, dest=3, data=0x00ABCD; busy[3]=1 between edges 1 and 2.
REQ-026 Load priority: queue holds {5:0x000011}, and ld_valid with dest=7, data=0xFFFFFF arrives at edge N -> write 7/0xFFFFFF after edge N, write 5/0x000011 after edge N+1.
REQ-027 Full back-pressure: the bench offers three ALU results while ld_valid is held high -> two accepted, alu_ready=0, the third is held. Then ld_valid drops -> one dequeue per edge, and the third is accepted the edge after alu_ready returns to 1; FIFO order is preserved.
REQ-028 Zero register: load dest=0, data=0x123456 and ALU dest=0 -> both consumed, q_count returns to 0, reg_write_en never 1, busy[0] always 0.
REQ-029 Mid-operation reset: q_count=2, ld_valid=1, and rst=1 for one edge -> the next cycle shows q_count=0, busy=0, reg_write_en=0, alu_ready=1 after deassertion.
REQ-030 Wrap-around: the bench issues 6 back-to-back ALU results with dests 1..6 and no loads -> writes appear in order 1..6, one per cycle, with q_count never exceeding 2.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: a 2-entry in-order ALU-result queue shares one
// registered write port with un-throttled load returns, which always take priority.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_dest,
    input  logic [23:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [3:0]  ld_dest,
    input  logic [23:0] ld_data,
    output logic        reg_write_en,
    output logic [3:0]  reg_write_dest,
    output logic [23:0] reg_write_data,
    output logic [15:0] busy,
    output logic [1:0]  q_count
);

    logic [3:0]  dest_mem_r [DEPTH];
    logic [23:0] data_mem_r [DEPTH];
    logic [1:0]  valid_r;
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        enq_s;
    logic        deq_s;
    logic [3:0]  head_dest_s;
    logic [23:0] head_data_s;
    logic [15:0] busy_s;

    assign q_count     = count_r;
    assign head_dest_s = dest_mem_r[rd_ptr_r];
    assign head_data_s = data_mem_r[rd_ptr_r];
    assign busy        = busy_s;

    // Handshake: readiness comes from registered occupancy only, loads block dequeue.
    always_comb begin
        alu_ready = 1'b0;
        if (!rst && (count_r < 2'd2)) begin
            alu_ready = 1'b1;
        end else begin
            alu_ready = 1'b0;
        end
        enq_s = alu_valid & alu_ready;
        deq_s = ~ld_valid & (count_r != 2'd0);
    end

    // Scoreboard of destinations still waiting in the queue; $zero is never busy.
    always_comb begin
        busy_s = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            busy_s = busy_s | (valid_r[i] ? (16'h0001 << dest_mem_r[i]) : 16'h0000);
        end
        busy_s[0] = 1'b0;
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_mem_r[i] <= 4'd0;
                data_mem_r[i] <= 24'd0;
            end
            valid_r  <= 2'b00;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq_s) begin
                dest_mem_r[wr_ptr_r] <= alu_dest;
                data_mem_r[wr_ptr_r] <= alu_data;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (deq_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= ~rd_ptr_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered write port: load first, else queue head, else idle holding dest/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= 4'd0;
            reg_write_data <= 24'd0;
        end else if (ld_valid) begin
            reg_write_en   <= (ld_dest != 4'd0);
            reg_write_dest <= ld_dest;
            reg_write_data <= ld_data;
        end else if (count_r != 2'd0) begin
            reg_write_en   <= (head_dest_s != 4'd0);
            reg_write_dest <= head_dest_s;
            reg_write_data <= head_data_s;
        end else begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= reg_write_dest;
            reg_write_data <= reg_write_data;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every write,
// a negedge monitor matches strobes against predictions including their edge number.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [23:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_dest;
    logic [23:0] ld_data;
    logic        reg_write_en;
    logic [3:0]  reg_write_dest;
    logic [23:0] reg_write_data;
    logic [15:0] busy;
    logic [1:0]  q_count;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .busy(busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] d; logic [23:0] v; } ent_t;
    typedef struct { logic [3:0] d; logic [23:0] v; int stamp; } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    bit   done = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] b = 16'h0000;
        foreach (mq[i]) b[mq[i].d] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic expect_write(input logic [3:0] d, input logic [23:0] v);
        exp_t e;
        if (d != 4'd0) begin
            e.d = d; e.v = v; e.stamp = edge_cnt + 1;
            sb.push_back(e);
        end
    endtask

    // Monitor: every strobe must match the oldest prediction, on the predicted edge.
    always @(negedge clk) begin
        exp_t e;
        if (!done && reg_write_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {28'd0, reg_write_dest}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("write_dest", {28'd0, reg_write_dest}, {28'd0, e.d});
                check("write_data", {8'd0, reg_write_data}, {8'd0, e.v});
                check("write_edge", edge_cnt, e.stamp);
            end
        end
    end

    // One clock: called at posedge+1, drives inputs, predicts the coming edge, checks state after it.
    task automatic cycle(input logic r, input logic av, input logic [3:0] ad, input logic [23:0] adat,
                         input logic lv, input logic [3:0] ldd, input logic [23:0] ldat, output logic acc);
        logic exp_rdy;
        ent_t e;
        rst = r; alu_valid = av; alu_dest = ad; alu_data = adat;
        ld_valid = lv; ld_dest = ldd; ld_data = ldat;
        #1;
        exp_rdy = !r && (mq.size() < 2);
        check("alu_ready", {31'd0, alu_ready}, {31'd0, exp_rdy});
        acc = av && exp_rdy;
        if (r) begin
            mq.delete();
        end else begin
            if (lv) begin
                expect_write(ldd, ldat);
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                expect_write(e.d, e.v);
            end
            if (acc) begin
                e.d = ad; e.v = adat;
                mq.push_back(e);
            end
        end
        @(posedge clk); #1;
        check("q_count", {30'd0, q_count}, mq.size());
        check("busy", {16'd0, busy}, {16'd0, model_busy()});
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 24'd0, a);
    endtask

    // Offer one ALU result, holding it until accepted, with the given load pattern each cycle.
    task automatic offer(input logic [3:0] ad, input logic [23:0] adat,
                         input logic lv, input logic [3:0] ldd, input logic [23:0] ldat);
        logic a = 1'b0;
        for (int k = 0; k < 12 && !a; k++) cycle(1'b0, 1'b1, ad, adat, lv, ldd, ldat, a);
        check("alu_accept_timeout", {31'd0, a}, 32'd1);
    endtask

    initial begin
        logic        a;
        logic        h_v = 1'b0;
        logic [3:0]  h_d = 4'd0;
        logic [23:0] h_x = 24'd0;
        logic        r, lv;
        logic [3:0]  ldd;
        logic [23:0] ldat;

        rst = 1'b1; alu_valid = 1'b0; alu_dest = 4'd0; alu_data = 24'd0;
        ld_valid = 1'b0; ld_dest = 4'd0; ld_data = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", {31'd0, reg_write_en}, 32'd0);
        check("rst_dest", {28'd0, reg_write_dest}, 32'd0);
        check("rst_data", {8'd0, reg_write_data}, 32'd0);
        check("rst_q_count", {30'd0, q_count}, 32'd0);
        check("rst_busy", {16'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, alu_ready}, 32'd0);

        // Single ALU result to r3.
        cycle(1'b0, 1'b1, 4'd3, 24'h00ABCD, 1'b0, 4'd0, 24'd0, a);
        idle(3);
        // Load overtakes a queued result.
        cycle(1'b0, 1'b1, 4'd5, 24'h000011, 1'b0, 4'd0, 24'd0, a);
        cycle(1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 4'd7, 24'hFFFFFF, a);
        idle(3);
        // Back-pressure: three results while loads stream, third is held until a slot opens.
        offer(4'd9, 24'h000901, 1'b1, 4'd12, 24'h0C0C0C);
        offer(4'd10, 24'h000A02, 1'b1, 4'd13, 24'h0D0D0D);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 4'd11, 24'h000B03, 1'b1, 4'd14, 24'h0E0E0E, a);
        offer(4'd11, 24'h000B03, 1'b0, 4'd0, 24'd0);
        idle(4);
        // $zero destinations are consumed silently.
        cycle(1'b0, 1'b1, 4'd0, 24'h654321, 1'b1, 4'd0, 24'h123456, a);
        idle(3);
        // Reset with a full queue and a load on the same edge.
        offer(4'd2, 24'h000222, 1'b1, 4'd4, 24'h444444);
        offer(4'd6, 24'h000666, 1'b1, 4'd4, 24'h444445);
        cycle(1'b1, 1'b0, 4'd0, 24'd0, 1'b1, 4'd8, 24'h888888, a);
        check("post_rst_en", {31'd0, reg_write_en}, 32'd0);
        idle(3);
        // Wrap-around: six back-to-back results.
        for (int k = 1; k <= 6; k++) offer(k[3:0], 24'h100000 + k, 1'b0, 4'd0, 24'd0);
        idle(4);

        // Randomized traffic; an unaccepted ALU offer is held unchanged.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(99) == 0);
            if (!h_v) begin
                h_v = ($urandom_range(9) < 7);
                h_d = 4'($urandom_range(15));
                h_x = 24'($urandom);
            end
            lv   = ($urandom_range(9) < 4);
            ldd  = 4'($urandom_range(15));
            ldat = 24'($urandom);
            cycle(r, h_v, h_d, h_x, lv, ldd, ldat, a);
            if (a || r) h_v = 1'b0;
        end
        idle(5);
        @(posedge clk); #1;
        done = 1'b1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
